frame_sum_accumulator: RTL and testbench

- Streaming consumer for 8-bit sample frames of fixed length `K_SIZE`.
- Accepts samples over a valid/ready input, accumulates each frame into a wide unsigned sum, and presents the sum on a valid/ready output.
- Also outputs the sum clamped to 8 bits and a sticky overflow flag.
- This is the hardware counterpart of the bench-side array generator/summer. It sits downstream of the sample source and feeds the result stage.

---
 rtl/frame_sum_accumulator.sv | 97 +++++++++
 tb/tb_frame_sum_accumulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_sum_accumulator.sv
// frame_sum_accumulator
//   Consumes fixed-length frames of K_SIZE unsigned samples over a valid/ready
//   input, sums each frame into a SUM_W-bit accumulator (wrapping modulo
//   2^SUM_W), and holds the result on a valid/ready output until it is taken.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   s_valid/s_ready    : sample handshake (s_ready high only while accumulating)
//   s_data [DATA_W]    : sample, zero-extended before the add
//   m_valid/m_ready    : result handshake (m_valid high only while holding)
//   m_sum [SUM_W]      : frame sum modulo 2^SUM_W
//   m_sat [DATA_W]     : m_sum clamped to 2^DATA_W-1
//   m_overflow         : a carry out of SUM_W bits occurred during the frame
module frame_sum_accumulator #(
    parameter int K_SIZE = 500,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [SUM_W-1:0]  m_sum,
    output logic [DATA_W-1:0] m_sat,
    output logic              m_overflow
);

    localparam int CNT_W = $clog2(K_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K_SIZE - 1);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Saturation limit widened to SUM_W+1 so the compare is legal even when
    // SUM_W == DATA_W (in which case it can never trip).
    localparam logic [SUM_W:0] SAT_LIM = {{(SUM_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    logic [0:0]       state;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [SUM_W:0]   add;
    logic [SUM_W-1:0] nxt;
    logic             carry;

    // Handshake outputs depend on state only, never on s_valid / m_ready.
    assign s_ready = (state == ST_ACC);
    assign m_valid = (state == ST_HOLD);

    assign add   = {1'b0, acc} + {{(SUM_W + 1 - DATA_W){1'b0}}, s_data};
    assign nxt   = add[SUM_W-1:0];
    assign carry = add[SUM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACC;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            m_sum      <= '0;
            m_sat      <= '0;
            m_overflow <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (s_valid) begin
                        if (cnt == LAST) begin
                            // Last sample: publish the result and start the
                            // next frame from a clean accumulator.
                            m_sum      <= nxt;
                            m_overflow <= ovf | carry;
                            m_sat      <= ({1'b0, nxt} > SAT_LIM) ? {DATA_W{1'b1}}
                                                                  : nxt[DATA_W-1:0];
                            acc        <= '0;
                            cnt        <= '0;
                            ovf        <= 1'b0;
                            state      <= ST_HOLD;
                        end else begin
                            acc <= nxt;
                            cnt <= cnt + CNT_W'(1);
                            ovf <= ovf | carry;
                        end
                    end
                end
                default: begin
                    // Result registers are left untouched while holding.
                    if (m_ready) state <= ST_ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sum_accumulator.sv
// Bench for frame_sum_accumulator. Five instances cover the parameter sets of
// interest: 0 = defaults (K=500), 1 = K=4, 2 = K=8, 3 = K=20/SUM_W=12, 4 = K=1.
// Expected results come from summing the intended sample list with plain
// wide arithmetic and reducing modulo 2^SUM_W.
module tb_frame_sum_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [5];
    logic        sv    [5];
    logic        sr    [5];
    logic [7:0]  sd    [5];
    logic        mv    [5];
    logic        mr    [5];
    logic [31:0] msum  [5];
    logic [7:0]  msat  [5];
    logic        movf  [5];
    logic [11:0] msum3;

    assign msum[3] = {20'd0, msum3};

    int sumw [5] = '{32, 32, 32, 12, 32};

    frame_sum_accumulator u_def (
        .clk(clk), .rst_n(rst_n[0]), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
        .m_valid(mv[0]), .m_ready(mr[0]), .m_sum(msum[0]), .m_sat(msat[0]), .m_overflow(movf[0]));
    frame_sum_accumulator #(.K_SIZE(4)) u_k4 (
        .clk(clk), .rst_n(rst_n[1]), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
        .m_valid(mv[1]), .m_ready(mr[1]), .m_sum(msum[1]), .m_sat(msat[1]), .m_overflow(movf[1]));
    frame_sum_accumulator #(.K_SIZE(8)) u_k8 (
        .clk(clk), .rst_n(rst_n[2]), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
        .m_valid(mv[2]), .m_ready(mr[2]), .m_sum(msum[2]), .m_sat(msat[2]), .m_overflow(movf[2]));
    frame_sum_accumulator #(.K_SIZE(20), .SUM_W(12)) u_ovf (
        .clk(clk), .rst_n(rst_n[3]), .s_valid(sv[3]), .s_ready(sr[3]), .s_data(sd[3]),
        .m_valid(mv[3]), .m_ready(mr[3]), .m_sum(msum3), .m_sat(msat[3]), .m_overflow(movf[3]));
    frame_sum_accumulator #(.K_SIZE(1)) u_k1 (
        .clk(clk), .rst_n(rst_n[4]), .s_valid(sv[4]), .s_ready(sr[4]), .s_data(sd[4]),
        .m_valid(mv[4]), .m_ready(mr[4]), .m_sum(msum[4]), .m_sat(msat[4]), .m_overflow(movf[4]));

    int nerr = 0;
    int nchk = 0;

    // Last expected result, used to check stability while the result is held.
    logic [63:0] exp_sum, exp_sat, exp_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain sum of the frame, wrap and overflow from the true total.
    task automatic model(input int unsigned q[$], input int sw);
        longint unsigned t = 0;
        longint unsigned m;
        m = 64'd1 << sw;
        foreach (q[k]) t += q[k];
        exp_ovf = (t >= m) ? 64'd1 : 64'd0;
        exp_sum = t % m;
        exp_sat = (exp_sum > 255) ? 64'd255 : exp_sum;
    endtask

    // Drive every sample of q through the handshake; gap is the percentage
    // of cycles with s_valid low. Returns the number of cycles spent.
    task automatic send(input int i, input int unsigned q[$], input int gap, output int cyc);
        int idx = 0;
        int guard = 0;
        bit acc;
        cyc = 0;
        while (idx < q.size() && guard < 5000) begin
            sv[i] = ($urandom_range(99) >= gap);
            sd[i] = sv[i] ? 8'(q[idx]) : 8'($urandom);
            acc = sv[i] && sr[i];
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
            cyc++;
        end
        sv[i] = 1'b0;
        if (idx < q.size()) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input int i, input int unsigned q[$], input string tag);
        model(q, sumw[i]);
        chk({tag, "_mvalid"}, 64'(mv[i]), 64'd1);
        chk({tag, "_sready"}, 64'(sr[i]), 64'd0);
        chk({tag, "_sum"}, 64'(msum[i]), exp_sum);
        chk({tag, "_sat"}, 64'(msat[i]), exp_sat);
        chk({tag, "_ovf"}, 64'(movf[i]), exp_ovf);
    endtask

    // Keep m_ready low for hold cycles (junk samples offered meanwhile),
    // then accept the result and confirm the block is back to accumulating.
    task automatic take_result(input int i, input int hold, input string tag);
        for (int c = 0; c < hold; c++) begin
            mr[i] = 1'b0;
            sv[i] = 1'b1;
            sd[i] = 8'd99;
            @(posedge clk); #1;
            chk({tag, "_hold_mv"}, 64'(mv[i]), 64'd1);
            chk({tag, "_hold_sr"}, 64'(sr[i]), 64'd0);
            chk({tag, "_hold_sum"}, 64'(msum[i]), exp_sum);
        end
        mr[i] = 1'b1;
        @(posedge clk); #1;
        sv[i] = 1'b0;
        chk({tag, "_rel_mv"}, 64'(mv[i]), 64'd0);
        chk({tag, "_rel_sr"}, 64'(sr[i]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned q[$];
        int cyc;

        for (int i = 0; i < 5; i++) begin
            rst_n[i] = 1'b0; sv[i] = 1'b0; sd[i] = 8'd0; mr[i] = 1'b1;
        end
        #3;
        for (int i = 0; i < 5; i++) begin
            chk("rst_sready", 64'(sr[i]), 64'd1);
            chk("rst_mvalid", 64'(mv[i]), 64'd0);
            chk("rst_sum", 64'(msum[i]), 64'd0);
            chk("rst_sat", 64'(msat[i]), 64'd0);
            chk("rst_ovf", 64'(movf[i]), 64'd0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) rst_n[i] = 1'b1;

        // Defaults: 500 x 10 back to back, then a random gapped frame.
        q = {};
        repeat (500) q.push_back(10);
        send(0, q, 0, cyc);
        chk("def_cycles", 64'(cyc), 64'd500);
        check_result(0, q, "def_const");
        chk("def_const_sum5000", 64'(msum[0]), 64'd5000);
        take_result(0, 0, "def_const");
        q = {};
        repeat (500) q.push_back($urandom_range(255));
        send(0, q, 20, cyc);
        check_result(0, q, "def_rand");
        take_result(0, 0, "def_rand");

        // K=4 boundary frames, then random ones.
        q = '{1, 2, 3, 4};     send(1, q, 0, cyc);  check_result(1, q, "k4_a"); take_result(1, 0, "k4_a");
        q = '{255, 0, 0, 0};   send(1, q, 0, cyc);  check_result(1, q, "k4_b"); take_result(1, 0, "k4_b");
        q = '{255, 1, 0, 0};   send(1, q, 0, cyc);  check_result(1, q, "k4_c"); take_result(1, 0, "k4_c");
        chk("k4_c_sat255", 64'(msat[1]), 64'd255);
        repeat (4) begin
            q = {};
            repeat (4) q.push_back($urandom_range(255));
            send(1, q, 30, cyc); check_result(1, q, "k4_r"); take_result(1, 2, "k4_r");
        end

        // K=8 handshake stress: gapped input, 20-cycle hold with junk offered.
        q = '{0, 1, 2, 3, 4, 5, 6, 7};
        send(2, q, 40, cyc); check_result(2, q, "k8_hs1"); take_result(2, 20, "k8_hs1");
        send(2, q, 40, cyc); check_result(2, q, "k8_hs2"); take_result(2, 0, "k8_hs2");

        // K=8 reset mid-frame.
        q = '{9, 9, 9, 9, 9};
        send(2, q, 0, cyc);
        rst_n[2] = 1'b0; #1;
        chk("k8_rstmid_sr", 64'(sr[2]), 64'd1);
        chk("k8_rstmid_mv", 64'(mv[2]), 64'd0);
        @(posedge clk); #1; rst_n[2] = 1'b1;
        q = '{2, 2, 2, 2, 2, 2, 2, 2};
        send(2, q, 0, cyc); check_result(2, q, "k8_after_rst"); take_result(2, 0, "k8_after_rst");

        // K=8 reset while holding: m_valid must drop without a clock edge.
        q = '{3, 3, 3, 3, 3, 3, 3, 3};
        send(2, q, 0, cyc); check_result(2, q, "k8_pre_hold_rst");
        mr[2] = 1'b0;
        rst_n[2] = 1'b0; #1;
        chk("k8_rsthold_mv", 64'(mv[2]), 64'd0);
        chk("k8_rsthold_sr", 64'(sr[2]), 64'd1);
        chk("k8_rsthold_sum", 64'(msum[2]), 64'd0);
        @(posedge clk); #1; rst_n[2] = 1'b1; mr[2] = 1'b1;
        q = '{5, 5, 5, 5, 5, 5, 5, 5};
        send(2, q, 25, cyc); check_result(2, q, "k8_after_rst2"); take_result(2, 0, "k8_after_rst2");

        // Overflow with SUM_W=12, then clean frame clears the flag.
        q = {};
        repeat (20) q.push_back(255);
        send(3, q, 0, cyc); check_result(3, q, "ovf_a");
        chk("ovf_a_sum1004", 64'(msum[3]), 64'd1004);
        take_result(3, 0, "ovf_a");
        q = {};
        repeat (20) q.push_back(0);
        send(3, q, 0, cyc); check_result(3, q, "ovf_b"); take_result(3, 0, "ovf_b");
        repeat (3) begin
            q = {};
            repeat (20) q.push_back($urandom_range(255));
            send(3, q, 15, cyc); check_result(3, q, "ovf_r"); take_result(3, 1, "ovf_r");
        end

        // K=1: every sample is a frame.
        q = '{7};   send(4, q, 0, cyc); check_result(4, q, "k1_7");   take_result(4, 0, "k1_7");
        q = '{200}; send(4, q, 0, cyc); check_result(4, q, "k1_200"); take_result(4, 0, "k1_200");
        q = '{0};   send(4, q, 0, cyc); check_result(4, q, "k1_0");   take_result(4, 0, "k1_0");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
